// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width derivation and Gray helper for both FIFO clock domains
package fifo_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_DATA_W = 8;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int ADDR_W = addr_w(DEF_DEPTH);
  localparam int PTR_W = ADDR_W + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side bus (W_ptr/RD_DATA/R_READY in, R_addr/R_ptr/R_EMPTY/R_VALID/R_DATA out of the controller)
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_W
);
  logic [ADDR_W:0] W_ptr, R_addr, R_ptr;
  logic [DATA_WIDTH-1:0] RD_DATA, R_DATA;
  logic R_READY, R_EMPTY, R_VALID;
  modport master(input W_ptr, RD_DATA, R_READY, output R_addr, R_ptr, R_EMPTY, R_VALID, R_DATA);
  modport slave(output W_ptr, RD_DATA, R_READY, input R_addr, R_ptr, R_EMPTY, R_VALID, R_DATA);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer (R_CLK, async active-low R_RST, d_i in, q_o out, resets to 0)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             R_CLK,
  input  logic             R_RST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q1_q;
  always_ff @(posedge R_CLK or negedge R_RST)
    if (!R_RST) begin
      q1_q <= '0;
      q_o  <= '0;
    end else begin
      q1_q <= d_i;
      q_o  <= q1_q;
    end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read-side controller (R_CLK, R_RST async low, bus: synced W_ptr -> empty flag, read pointers, FWFT R_DATA/R_VALID/R_READY)
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input logic R_CLK,
  input logic R_RST,
  fifo_rd_ctrl_if.master bus
);
  localparam int PW = addr_w(MEM_DEPTH) + 1;
  logic [PW-1:0] wq2, addr_q, addr_d, ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic empty_q, empty_d, valid_q, valid_d, pop;
  sync_2ff #(.WIDTH(PW)) u_wsync (
    .R_CLK(R_CLK),
    .R_RST(R_RST),
    .d_i  (bus.W_ptr),
    .q_o  (wq2)
  );
  always_ff @(posedge R_CLK or negedge R_RST)
    if (!R_RST) begin
      addr_q  <= '0;
      ptr_q   <= '0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  always_comb begin
    pop     = !empty_q && (!valid_q || bus.R_READY);
    addr_d  = addr_q + PW'(pop);
    ptr_d   = PW'(bin2gray(32'(addr_d)));
    // comparing the next Gray pointer lets the final pop raise empty on the same edge
    empty_d = ptr_d == wq2;
    valid_d = pop || (valid_q && !bus.R_READY);
    data_d  = pop ? bus.RD_DATA : data_q;
  end
  always_comb begin
    bus.R_addr  = addr_q;
    bus.R_ptr   = ptr_q;
    bus.R_EMPTY = empty_q;
    bus.R_VALID = valid_q;
    bus.R_DATA  = data_q;
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for fifo_rd_ctrl with a modeled write side and memory
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;
  logic R_CLK = 1'b0;
  logic R_RST = 1'b0;
  fifo_rd_ctrl_if #(.ADDR_W(3), .DATA_WIDTH(8)) bus ();
  fifo_rd_ctrl #(.MEM_DEPTH(8), .DATA_WIDTH(8)) dut (
    .R_CLK(R_CLK),
    .R_RST(R_RST),
    .bus  (bus)
  );
  always #5 R_CLK = ~R_CLK;
  logic [7:0] mem [8];
  logic [7:0] sbq [$];
  logic [3:0] wcnt;
  logic [3:0] prev_ptr, prev_addr;
  int n_chk = 0, n_err = 0;
  bit gray_en = 0, saw_wrap = 0;
  assign bus.RD_DATA = mem[bus.R_addr[2:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge R_CLK);
    #1;
  endtask
  task automatic write_word(input logic [7:0] d);
    mem[wcnt[2:0]] = d;
    sbq.push_back(d);
    wcnt = wcnt + 4'd1;
    bus.W_ptr = 4'(bin2gray(32'(wcnt)));
  endtask
  task automatic do_reset();
    R_RST = 1'b0;
    #1;
    sbq.delete();
    wcnt = '0;
    bus.W_ptr = '0;
    bus.R_READY = 1'b0;
    tick(2);
    R_RST = 1'b1;
    tick(1);
  endtask
  always @(negedge R_CLK) begin
    if (R_RST && bus.R_VALID && bus.R_READY) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) chk("data", 32'(bus.R_DATA), 32'(sbq.pop_front()));
    end
    if (gray_en && bus.R_ptr != prev_ptr) chk("gray_step", $countones(bus.R_ptr ^ prev_ptr), 1);
    if (gray_en && prev_addr == 4'd15 && bus.R_addr == 4'd0) saw_wrap = 1;
    prev_ptr = bus.R_ptr;
    prev_addr = bus.R_addr;
  end
  initial begin
    int written, it;
    bus.W_ptr = '0;
    bus.R_READY = 1'b0;
    wcnt = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    tick(2);
    R_RST = 1'b1;
    tick(1);
    chk("rst_empty", 32'(bus.R_EMPTY), 1);
    chk("rst_valid", 32'(bus.R_VALID), 0);
    chk("rst_addr", 32'(bus.R_addr), 0);
    chk("rst_ptr", 32'(bus.R_ptr), 0);
    chk("rst_data", 32'(bus.R_DATA), 0);
    tick(10);
    chk("idle_addr", 32'(bus.R_addr), 0);
    chk("idle_empty", 32'(bus.R_EMPTY), 1);
    chk("idle_valid", 32'(bus.R_VALID), 0);
    bus.R_READY = 1'b1;
    write_word(8'hA5);
    tick(2);
    chk("sw_empty_k1", 32'(bus.R_EMPTY), 1);
    tick(1);
    chk("sw_empty_k2", 32'(bus.R_EMPTY), 0);
    chk("sw_valid_k2", 32'(bus.R_VALID), 0);
    tick(1);
    chk("sw_valid_k3", 32'(bus.R_VALID), 1);
    chk("sw_data_k3", 32'(bus.R_DATA), 32'h A5);
    chk("sw_empty_k3", 32'(bus.R_EMPTY), 1);
    chk("sw_addr_k3", 32'(bus.R_addr), 1);
    tick(1);
    chk("sw_valid_k4", 32'(bus.R_VALID), 0);
    do_reset();
    bus.R_READY = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
    for (int i = 0; i < 10 && !bus.R_VALID; i++) tick(1);
    chk("drain_start", 32'(bus.R_VALID), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(bus.R_VALID), 1);
      tick(1);
    end
    chk("drain_addr", 32'(bus.R_addr), 8);
    chk("drain_ptr", 32'(bus.R_ptr), 32'b1100);
    chk("drain_empty", 32'(bus.R_EMPTY), 1);
    chk("drain_valid_end", 32'(bus.R_VALID), 0);
    bus.R_READY = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'(8'h20 + i));
    for (int i = 0; i < 10 && !bus.R_VALID; i++) tick(1);
    chk("bp_start", 32'(bus.R_VALID), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.R_VALID), 1);
      chk("bp_data", 32'(bus.R_DATA), 32'h20);
      chk("bp_addr", 32'(bus.R_addr), 9);
      tick(1);
    end
    bus.R_READY = 1'b1;
    tick(8);
    chk("bp_final_addr", 32'(bus.R_addr), 12);
    chk("bp_sb_empty", 32'(sbq.size()), 0);
    chk("bp_empty", 32'(bus.R_EMPTY), 1);
    gray_en = 1;
    saw_wrap = 0;
    written = 0;
    it = 0;
    while (written < 20 && it < 500) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n && written < 20 && 4'(wcnt - bus.R_addr) < 4'd8; i++) begin
        write_word(8'(8'h40 + written));
        written++;
      end
      bus.R_READY = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 4));
      it++;
    end
    chk("wrap_written", 32'(written), 20);
    bus.R_READY = 1'b1;
    for (int i = 0; i < 60 && (sbq.size() != 0 || bus.R_VALID); i++) tick(1);
    chk("wrap_drained", 32'(sbq.size()), 0);
    chk("wrap_addr", 32'(bus.R_addr), 0);
    chk("wrap_seen", 32'(saw_wrap), 1);
    gray_en = 0;
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'(8'h60 + i));
    bus.R_READY = 1'b1;
    for (int i = 0; i < 20 && bus.R_addr != 4'd5; i++) tick(1);
    bus.R_READY = 1'b0;
    chk("mid_addr", 32'(bus.R_addr), 5);
    chk("mid_valid", 32'(bus.R_VALID), 1);
    #2;
    R_RST = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(bus.R_addr), 0);
    chk("mid_rst_ptr", 32'(bus.R_ptr), 0);
    chk("mid_rst_empty", 32'(bus.R_EMPTY), 1);
    chk("mid_rst_valid", 32'(bus.R_VALID), 0);
    chk("mid_rst_data", 32'(bus.R_DATA), 0);
    sbq.delete();
    wcnt = '0;
    bus.W_ptr = '0;
    tick(2);
    R_RST = 1'b1;
    tick(3);
    chk("post_empty", 32'(bus.R_EMPTY), 1);
    chk("post_valid", 32'(bus.R_VALID), 0);
    chk("post_addr", 32'(bus.R_addr), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller of the dual-clock FIFO, sitting in the read clock domain opposite the write-side pointer/full-flag block. It brings the write domain's Gray pointer into the read domain through a two-flop synchronizer and generates a registered empty flag. It advances a binary/Gray read pointer and drives the shared memory's read address. A one-entry first-word-fall-through output register presents data to the consumer with a valid/ready handshake.

## Interface
- MEM_DEPTH, 8, FIFO entries; power of two, ≥ 2; ADDR_W = $clog2(MEM_DEPTH)
- DATA_WIDTH, 8, width of a stored word
- R_CLK  in  1  read-domain clock
- R_RST  in  1  asynchronous, active-low reset of all read-domain state
- W_ptr  in  ADDR_W+1  Gray write pointer from the write domain, unsynchronized
- RD_DATA  in  DATA_WIDTH  memory read data; combinational function of R_addr[ADDR_W-1:0]
- R_READY  in  1  consumer accepts R_DATA this cycle
- R_addr  out  ADDR_W+1  binary read pointer; memory uses the low ADDR_W bits
- R_ptr  out  ADDR_W+1  registered Gray read pointer, sent to the write domain
- R_EMPTY  out  1  registered empty flag
- R_VALID  out  1  R_DATA holds an unconsumed word
- R_DATA  out  DATA_WIDTH  output word

## Operation
- Synchronizer:
  - WQ1 <= W_ptr; WQ2 <= WQ1.
  - WQ2 is the only read-domain use of W_ptr.
- Pop: pop = !R_EMPTY && (!R_VALID || R_READY).
- Pointers:
  - rbin_next = R_addr + pop, modulo 2^(ADDR_W+1), with natural wrap.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - Each cycle: R_addr <= rbin_next; R_ptr <= rgray_next.
- Empty: R_EMPTY <= (rgray_next == WQ2).
  - Full-width compare; generic in ADDR_W, with no hard-coded bit indices.
- Output register:
  - If pop: R_DATA <= RD_DATA (word at the current R_addr); R_VALID <= 1.
  - Else if R_VALID && R_READY: R_VALID <= 0; R_DATA holds.
  - Else: hold.
- Simultaneous consume and pop: R_VALID stays 1 and R_DATA takes the next word with no bubble.
- Consume while empty: R_VALID falls. R_DATA keeps the stale value and is don't-care.
- R_READY while R_VALID = 0: ignored.
- Reset (asynchronous assert, any time, including mid-transfer):
  - R_addr = 0, R_ptr = 0, WQ1 = WQ2 = 0.
  - R_EMPTY = 1, R_VALID = 0, R_DATA = 0.
  - Any in-flight word is discarded.
- Never pops when R_EMPTY = 1, so R_addr never passes the synchronized write pointer.

## Timing
- W_ptr change sampled at edge k:
  - WQ2 updates after k+1.
  - R_EMPTY deasserts after k+2.
  - pop at k+3; R_VALID = 1 after k+3.
  - Write-to-visible latency: 4 R_CLK edges.
- Sustained throughput with R_READY held high and the FIFO non-empty: one word per R_CLK.
- R_ptr reflects a pop one edge after it; the write domain sees it after its own 2-flop synchronizer.
- The last word popped sets R_EMPTY on the same edge that loads that word into R_DATA.
- Pointer wrap: at the transition from 2·MEM_DEPTH−1 to 0, both binary and Gray wrap cleanly. The Gray code changes exactly one bit per pop.

## Structure
- Package fifo_pkg holds:
  - ADDR_W derivation from MEM_DEPTH;
  - bin2gray function;
  - the shared pointer-width constant, so the write side uses the same definitions.
- Sub-module sync_2ff #(WIDTH):
  - a generic two-flop synchronizer with R_CLK and R_RST, reset value 0;
  - instantiated once for W_ptr; reused on the write side for R_ptr.

## Test plan
- Reset release with W_ptr = 0: R_EMPTY = 1, R_VALID = 0, R_addr = 0, R_ptr = 0; no pop for 10 cycles.
- Single write: W_ptr steps 0→1 (Gray) at edge k, R_READY = 1, RD_DATA = 8'hA5.
  - R_EMPTY = 0 after k+2.
  - R_VALID = 1 with R_DATA = 8'hA5 after k+3.
  - R_EMPTY = 1 again and R_addr = 1 after k+3.
  - R_VALID = 0 after k+4.
- Full drain, MEM_DEPTH = 8: W_ptr = Gray(8), R_READY = 1.
  - Eight consecutive words, one per cycle.
  - R_addr ends at 8, R_ptr = 4'b1100, R_EMPTY = 1.
- Backpressure: four words available, R_READY = 0 for 5 cycles.
  - R_VALID = 1 and R_DATA holds the first word.
  - R_addr advances by exactly 1 and no further until R_READY = 1.
- Wrap-around: 20 writes/reads in interleaved bursts.
  - R_addr wraps 15→0.
  - Every R_ptr transition differs from the previous value in exactly one bit.
  - Data order is preserved.
- Mid-stream reset: R_RST asserted while R_VALID = 1 and R_addr = 5.
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - After release, W_ptr = 0 gives R_EMPTY = 1.
